tinker_cpu: RTL and testbench

Single-cycle 64-bit Tinker-subset processor with an internal byte-addressed unified memory. It is the top of the processor hierarchy: a loader fills memory during reset, then the core fetches and executes 32-bit instructions from PC 0x2000 until a halt. A simple 64-bit input/output port is exposed through privileged instructions.

---
 rtl/tinker_cpu.sv | 145 ++++++++++++++
 tb/tb_tinker_cpu.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tinker_cpu.sv
// tinker_cpu: single-cycle 64-bit Tinker-subset core with unified byte-addressed memory and a simple I/O port
module tinker_memory #(
  parameter int MEM_SIZE = 524288,
  parameter int AW = $clog2(MEM_SIZE)
) (
  input  logic          clk,
  input  logic [AW-1:0] fetch_addr,
  output logic [31:0]   instr,
  input  logic [AW-1:0] data_addr,
  output logic [63:0]   rdata,
  input  logic          we,
  input  logic [63:0]   wdata
);
  logic [7:0] bytes [0:MEM_SIZE-1];
  for (genvar g = 0; g < 8; g++) begin : g_rd
    if (g < 4) begin : g_fetch
      assign instr[8*g+:8] = bytes[fetch_addr + AW'(g)];
    end
    assign rdata[8*g+:8] = bytes[data_addr + AW'(g)];
  end
  always_ff @(posedge clk)
    if (we) for (int i = 0; i < 8; i++) bytes[data_addr + AW'(i)] <= wdata[8*i+:8];
endmodule

module tinker_cpu #(
  parameter int          MEM_SIZE = 524288,
  parameter logic [63:0] START_PC = 64'h2000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        halt,
  input  logic        in_signal,
  input  logic [63:0] in_data,
  output logic        out_signal,
  output logic [63:0] out_data
);
  localparam int AW = $clog2(MEM_SIZE);
  localparam logic [63:0] MSZ = 64'(MEM_SIZE);
  logic [63:0] pc, next_pc, rd_v, rs_v, rt_v, sl, zl, wr_val, mem_addr, mem_wdata, mem_rdata;
  logic [63:0] regs [0:31];
  logic [31:0] instr;
  logic [4:0]  op, rd, rs, rt;
  logic [11:0] l;
  logic wr_en, mem_acc, mem_we, bad, stop_op, out_en, stop;
  assign {op, rd, rs, rt, l} = instr;
  assign rd_v = regs[rd];
  assign rs_v = regs[rs];
  assign rt_v = regs[rt];
  assign sl = {{52{l[11]}}, l};
  assign zl = {52'd0, l};
  tinker_memory #(.MEM_SIZE(MEM_SIZE)) memory (
    .clk        (clk),
    .fetch_addr (pc[AW-1:0]),
    .instr      (instr),
    .data_addr  (mem_addr[AW-1:0]),
    .rdata      (mem_rdata),
    .we         (mem_we & ~stop & ~halt & ~reset),
    .wdata      (mem_wdata)
  );
  always_comb begin
    next_pc = pc + 64'd4;
    wr_en = 1'b0;
    wr_val = 64'd0;
    mem_acc = 1'b0;
    mem_we = 1'b0;
    mem_addr = 64'd0;
    mem_wdata = 64'd0;
    bad = 1'b0;
    stop_op = 1'b0;
    out_en = 1'b0;
    case (op)
      5'h00: {wr_en, wr_val} = {1'b1, rs_v & rt_v};
      5'h01: {wr_en, wr_val} = {1'b1, rs_v | rt_v};
      5'h02: {wr_en, wr_val} = {1'b1, rs_v ^ rt_v};
      5'h03: {wr_en, wr_val} = {1'b1, ~rs_v};
      5'h04: {wr_en, wr_val} = {1'b1, rs_v >> rt_v[5:0]};
      5'h05: {wr_en, wr_val} = {1'b1, rd_v >> l};
      5'h06: {wr_en, wr_val} = {1'b1, rs_v << rt_v[5:0]};
      5'h07: {wr_en, wr_val} = {1'b1, rd_v << l};
      5'h08: next_pc = rd_v;
      5'h09: next_pc = pc + rd_v;
      5'h0A: next_pc = pc + sl;
      5'h0B: if (rs_v != 64'd0) next_pc = rd_v;
      5'h0C: begin
        mem_acc = 1'b1;
        mem_we = 1'b1;
        mem_addr = regs[31] - 64'd8;
        mem_wdata = pc + 64'd4;
        next_pc = rd_v;
      end
      5'h0D: begin
        mem_acc = 1'b1;
        mem_addr = regs[31] - 64'd8;
        next_pc = mem_rdata;
      end
      5'h0E: if ($signed(rs_v) > $signed(rt_v)) next_pc = rd_v;
      5'h0F: case (l)
        12'd0: stop_op = 1'b1;
        12'd1, 12'd2: ;
        12'd3: if (in_signal) {wr_en, wr_val} = {1'b1, in_data}; else next_pc = pc;
        12'd4: out_en = 1'b1;
        default: bad = 1'b1;
      endcase
      5'h10: begin
        mem_acc = 1'b1;
        mem_addr = rs_v + sl;
        {wr_en, wr_val} = {1'b1, mem_rdata};
      end
      5'h11: {wr_en, wr_val} = {1'b1, rs_v};
      5'h12: {wr_en, wr_val} = {1'b1, rd_v[63:12], l};
      5'h13: begin
        mem_acc = 1'b1;
        mem_we = 1'b1;
        mem_addr = rd_v + sl;
        mem_wdata = rs_v;
      end
      5'h18: {wr_en, wr_val} = {1'b1, rs_v + rt_v};
      5'h19: {wr_en, wr_val} = {1'b1, rd_v + zl};
      5'h1A: {wr_en, wr_val} = {1'b1, rs_v - rt_v};
      5'h1B: {wr_en, wr_val} = {1'b1, rd_v - zl};
      5'h1C: {wr_en, wr_val} = {1'b1, rs_v * rt_v};
      5'h1D: {wr_en, wr_val} = {1'b1, (rt_v == 64'd0) ? 64'd0 : rs_v / rt_v};
      default: bad = 1'b1;
    endcase
  end
  assign stop = bad | stop_op | (pc > MSZ - 64'd4) | (mem_acc & (mem_addr > MSZ - 64'd8));
  always_ff @(posedge clk)
    if (reset) begin
      pc <= START_PC;
      for (int i = 0; i < 32; i++) regs[i] <= (i == 31) ? MSZ : 64'd0;
      halt <= 1'b0;
      out_signal <= 1'b0;
      out_data <= 64'd0;
    end else if (halt) begin
      out_signal <= 1'b0;
    end else if (stop) begin
      halt <= 1'b1;
      out_signal <= 1'b0;
    end else begin
      pc <= next_pc;
      out_signal <= out_en;
      if (wr_en) regs[rd] <= wr_val;
      if (out_en) out_data <= rs_v;
    end
endmodule

// File: tb/tb_tinker_cpu.sv
// tb_tinker_cpu: scoreboard bench loading small programs into tinker_cpu and checking results after halt
module tb_tinker_cpu;
  localparam int MS = 524288;
  logic clk = 1'b0, reset = 1'b1, in_signal = 1'b0, halt, out_signal;
  logic [63:0] in_data = 64'd0, out_data;
  tinker_cpu #(.MEM_SIZE(MS), .START_PC(64'h2000)) dut (
    .clk        (clk),
    .reset      (reset),
    .halt       (halt),
    .in_signal  (in_signal),
    .in_data    (in_data),
    .out_signal (out_signal),
    .out_data   (out_data)
  );
  always #5 clk = ~clk;
  typedef struct {string tag; int regn; logic [63:0] val;} exp_t;
  exp_t sb[$];
  logic [63:0] out_q[$];
  logic [31:0] prog[$];
  int tests = 0, fails = 0, out_cnt = 0, n;
  logic [31:0] w;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] enc(input int op, input int rd, input int rs, input int rt, input int l);
    logic [31:0] r;
    r = {op[4:0], rd[4:0], rs[4:0], rt[4:0], l[11:0]};
    return r;
  endfunction
  function automatic logic [63:0] peek64(input int a);
    logic [63:0] v;
    for (int b = 0; b < 8; b++) v[8*b+:8] = dut.memory.bytes[a+b];
    return v;
  endfunction
  task automatic load(input int base);
    foreach (prog[i]) for (int b = 0; b < 4; b++) dut.memory.bytes[base+4*i+b] = prog[i][8*b+:8];
    prog.delete();
  endtask
  task automatic exp_reg(input string tag, input int r, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.regn = r;
    e.val = v;
    sb.push_back(e);
  endtask
  task automatic drain;
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, (e.regn == 32) ? dut.pc : dut.regs[e.regn], e.val);
    end
  endtask
  task automatic begin_reset;
    reset = 1'b1;
    @(negedge clk);
  endtask
  task automatic end_reset;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic run(input int max, output int cyc);
    cyc = 0;
    while (!halt && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    if (!halt) check("timeout", {63'd0, halt}, 64'd1);
  endtask
  always @(negedge clk)
    if (!reset && out_signal) begin
      out_cnt++;
      if (out_q.size() > 0) check("out_data", out_data, out_q.pop_front());
      else check("out_extra", {63'd0, out_signal}, 64'd0);
    end
  initial begin
    // basic_add, with reset-state and cycle-count checks
    w = enc(5'h18, 3, 1, 2, 0);
    prog = {enc(5'h12, 1, 0, 0, 5), enc(5'h12, 2, 0, 0, 7), w, enc(5'h0F, 0, 0, 0, 0)};
    begin_reset;
    load(32'h2000);
    end_reset;
    reset = 1'b1;
    @(negedge clk);
    check("rst_pc", dut.pc, 64'h2000);
    check("rst_sp", dut.regs[31], 64'(MS));
    check("rst_halt", {63'd0, halt}, 64'd0);
    check("rst_out_sig", {63'd0, out_signal}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("load_byte", {56'd0, dut.memory.bytes[32'h2008]}, {56'd0, w[7:0]});
    reset = 1'b0;
    run(20, n);
    check("p1_cycles", 64'(n), 64'd4);
    exp_reg("p1_r3", 3, 64'd12);
    exp_reg("p1_pc", 32, 64'h200C);
    drain;
    begin_reset;
    @(negedge clk);
    check("mem_keep", {56'd0, dut.memory.bytes[32'h200B]}, {56'd0, w[31:24]});
    check("rst_r3", dut.regs[3], 64'd0);
    check("rst_halt2", {63'd0, halt}, 64'd0);
    // ALU coverage
    prog = {enc(5'h12, 1, 0, 0, 12'hF0F), enc(5'h12, 2, 0, 0, 12'h0FF), enc(5'h00, 3, 1, 2, 0),
            enc(5'h01, 4, 1, 2, 0), enc(5'h02, 5, 1, 2, 0), enc(5'h03, 6, 1, 0, 0), enc(5'h12, 7, 0, 0, 4),
            enc(5'h04, 8, 1, 7, 0), enc(5'h06, 9, 1, 7, 0), enc(5'h1A, 10, 2, 1, 0), enc(5'h1C, 11, 1, 2, 0),
            enc(5'h1D, 12, 1, 7, 0), enc(5'h1D, 13, 1, 0, 0), enc(5'h12, 14, 0, 0, 10), enc(5'h19, 14, 0, 0, 12'hFFF),
            enc(5'h12, 15, 0, 0, 5), enc(5'h1B, 15, 0, 0, 6), enc(5'h12, 16, 0, 0, 12'h800), enc(5'h05, 16, 0, 0, 3),
            enc(5'h11, 17, 1, 0, 0), enc(5'h18, 18, 6, 1, 0), enc(5'h03, 19, 0, 0, 0), enc(5'h12, 19, 0, 0, 12'h123),
            enc(5'h0F, 0, 0, 0, 0)};
    load(32'h2000);
    end_reset;
    exp_reg("and", 3, 64'h00F);
    exp_reg("or", 4, 64'hFFF);
    exp_reg("xor", 5, 64'hFF0);
    exp_reg("not", 6, ~64'hF0F);
    exp_reg("shftr", 8, 64'hF0);
    exp_reg("shftl", 9, 64'hF0F0);
    exp_reg("sub", 10, 64'hFF - 64'hF0F);
    exp_reg("mul", 11, 64'hF0F * 64'hFF);
    exp_reg("div", 12, 64'h3C3);
    exp_reg("div0", 13, 64'd0);
    exp_reg("addi", 14, 64'd4105);
    exp_reg("subi", 15, 64'hFFFF_FFFF_FFFF_FFFF);
    exp_reg("shftri", 16, 64'h100);
    exp_reg("mov_rr", 17, 64'hF0F);
    exp_reg("add_wrap", 18, 64'hFFFF_FFFF_FFFF_FFFF);
    exp_reg("mov_lit", 19, 64'hFFFF_FFFF_FFFF_F123);
    run(100, n);
    drain;
    // store/load of a 64-bit pattern, including a negative offset
    begin_reset;
    prog = {enc(5'h12, 5, 0, 0, 1), enc(5'h07, 5, 0, 0, 12), enc(5'h12, 5, 0, 0, 12'h122), enc(5'h07, 5, 0, 0, 12),
            enc(5'h12, 5, 0, 0, 12'h334), enc(5'h07, 5, 0, 0, 12), enc(5'h12, 5, 0, 0, 12'h455), enc(5'h07, 5, 0, 0, 12),
            enc(5'h12, 5, 0, 0, 12'h667), enc(5'h07, 5, 0, 0, 12), enc(5'h12, 5, 0, 0, 12'h788),
            enc(5'h12, 4, 0, 0, 12'h100), enc(5'h13, 4, 5, 0, 0), enc(5'h10, 6, 4, 0, 0),
            enc(5'h12, 8, 0, 0, 12'h108), enc(5'h10, 7, 8, 0, 12'hFF8), enc(5'h0F, 0, 0, 0, 0)};
    load(32'h2000);
    end_reset;
    exp_reg("r5", 5, 64'h1122334455667788);
    exp_reg("load", 6, 64'h1122334455667788);
    exp_reg("load_neg", 7, 64'h1122334455667788);
    run(100, n);
    drain;
    check("byte100", {56'd0, dut.memory.bytes[32'h100]}, 64'h88);
    check("byte107", {56'd0, dut.memory.bytes[32'h107]}, 64'h11);
    // brnz/call/return loop, brr L, brgt
    begin_reset;
    prog = {enc(5'h12, 1, 0, 0, 3), enc(5'h12, 10, 0, 0, 2), enc(5'h07, 10, 0, 0, 12), enc(5'h12, 10, 0, 0, 12'h080),
            enc(5'h12, 11, 0, 0, 2), enc(5'h07, 11, 0, 0, 12), enc(5'h12, 11, 0, 0, 12'h01C), enc(5'h0C, 10, 0, 0, 0),
            enc(5'h1B, 1, 0, 0, 1), enc(5'h0B, 11, 1, 0, 0), enc(5'h0A, 0, 0, 0, 8), enc(5'h0F, 0, 0, 0, 0),
            enc(5'h1B, 6, 0, 0, 1), enc(5'h12, 7, 0, 0, 1), enc(5'h12, 8, 0, 0, 2), enc(5'h07, 8, 0, 0, 12),
            enc(5'h12, 8, 0, 0, 12'h050), enc(5'h0E, 8, 6, 7, 0), enc(5'h0E, 8, 7, 6, 0), enc(5'h0F, 0, 0, 0, 0),
            enc(5'h0F, 0, 0, 0, 0)};
    load(32'h2000);
    prog = {enc(5'h19, 2, 0, 0, 1), enc(5'h0D, 0, 0, 0, 0)};
    load(32'h2080);
    end_reset;
    exp_reg("loop_r1", 1, 64'd0);
    exp_reg("loop_iters", 2, 64'd3);
    exp_reg("br_pc", 32, 64'h2050);
    run(200, n);
    drain;
    check("ret_addr", peek64(MS - 8), 64'h2020);
    // priv input stall and output strobe
    begin_reset;
    prog = {enc(5'h0F, 1, 0, 0, 3), enc(5'h12, 2, 0, 0, 99), enc(5'h0F, 0, 2, 0, 4), enc(5'h0F, 0, 0, 0, 0)};
    load(32'h2000);
    in_signal = 1'b0;
    end_reset;
    out_cnt = 0;
    out_q.push_back(64'd99);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall_pc%0d", k), dut.pc, 64'h2000);
    end
    in_data = 64'd42;
    in_signal = 1'b1;
    @(negedge clk);
    in_signal = 1'b0;
    check("in_pc", dut.pc, 64'h2004);
    exp_reg("in_r1", 1, 64'd42);
    run(20, n);
    drain;
    check("out_pulses", 64'(out_cnt), 64'd1);
    check("out_missing", 64'(out_q.size()), 64'd0);
    check("out_hold", out_data, 64'd99);
    check("out_sig_low", {63'd0, out_signal}, 64'd0);
    // fault on float opcode; state frozen afterwards
    begin_reset;
    prog = {enc(5'h12, 1, 0, 0, 5), enc(5'h14, 1, 1, 1, 0), enc(5'h12, 1, 0, 0, 9), enc(5'h0F, 0, 0, 0, 0)};
    load(32'h2000);
    end_reset;
    run(20, n);
    repeat (3) @(negedge clk);
    exp_reg("f14_pc", 32, 64'h2004);
    exp_reg("f14_r1", 1, 64'd5);
    drain;
    check("f14_halt", {63'd0, halt}, 64'd1);
    // load at MEM_SIZE-8 succeeds, at MEM_SIZE-4 faults
    begin_reset;
    for (int i = 0; i < 8; i++) dut.memory.bytes[MS-8+i] = 8'(i + 1);
    prog = {enc(5'h11, 2, 31, 0, 0), enc(5'h1B, 2, 0, 0, 4), enc(5'h10, 4, 2, 0, 12'hFFC),
            enc(5'h10, 3, 2, 0, 0), enc(5'h12, 3, 0, 0, 1), enc(5'h0F, 0, 0, 0, 0)};
    load(32'h2000);
    end_reset;
    exp_reg("edge_load", 4, 64'h0807060504030201);
    exp_reg("fault_r3", 3, 64'd0);
    exp_reg("fault_pc", 32, 64'h200C);
    run(20, n);
    repeat (2) @(negedge clk);
    drain;
    // store at MEM_SIZE-4 faults without touching memory
    begin_reset;
    prog = {enc(5'h11, 2, 31, 0, 0), enc(5'h1B, 2, 0, 0, 4), enc(5'h12, 5, 0, 0, 12'h777),
            enc(5'h13, 2, 5, 0, 0), enc(5'h0F, 0, 0, 0, 0)};
    load(32'h2000);
    end_reset;
    exp_reg("st_fault_pc", 32, 64'h200C);
    run(20, n);
    repeat (2) @(negedge clk);
    drain;
    check("st_fault_mem", peek64(MS - 8), 64'h0807060504030201);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
